// File: rtl/ysyx_22040632_div_seq_pkg.sv
// rtl/ysyx_22040632_div_seq_pkg.sv - shared types and constants for the divide sequencer
package ysyx_22040632_div_seq_pkg;

  localparam int DIV_XLEN = 64;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } div_state_e;

  typedef struct packed {
    logic                sgn;
    logic                word;
    logic [DIV_XLEN-1:0] dividend;
    logic [DIV_XLEN-1:0] divisor;
  } div_key_t;

  // Word operands are sign-extended before the overflow test, so the word minimum lives here.
  localparam logic [DIV_XLEN-1:0] MOST_NEG   = 64'h8000_0000_0000_0000;
  localparam logic [DIV_XLEN-1:0] MOST_NEG_W = 64'hFFFF_FFFF_8000_0000;

  function automatic logic [DIV_XLEN-1:0] sext_w(input logic [DIV_XLEN-1:0] v);
    return {{(DIV_XLEN-32){v[31]}}, v[31:0]};
  endfunction

endpackage

// File: rtl/ysyx_22040632_div_special.sv
// rtl/ysyx_22040632_div_special.sv - operand extension and div-by-zero/overflow result generation
module ysyx_22040632_div_special
  import ysyx_22040632_div_seq_pkg::*;
(
  input  logic                i_signed,
  input  logic                i_word,
  input  logic [DIV_XLEN-1:0] i_dividend,
  input  logic [DIV_XLEN-1:0] i_divisor,
  output logic [DIV_XLEN-1:0] o_dividend,
  output logic [DIV_XLEN-1:0] o_divisor,
  output logic                o_special,
  output logic [DIV_XLEN-1:0] o_quotient,
  output logic [DIV_XLEN-1:0] o_remainder
);

  logic w_zero;
  logic w_ovf;

  always_comb begin
    o_dividend = i_dividend;
    o_divisor  = i_divisor;
    if (i_word) begin
      o_dividend = i_signed ? sext_w(i_dividend) : {32'b0, i_dividend[31:0]};
      o_divisor  = i_signed ? sext_w(i_divisor)  : {32'b0, i_divisor[31:0]};
    end
  end

  assign w_zero = (o_divisor == '0);
  assign w_ovf  = i_signed && (o_divisor == '1) &&
                  (o_dividend == (i_word ? MOST_NEG_W : MOST_NEG));

  assign o_special   = w_zero || w_ovf;
  // Overflow returns the dividend as quotient; division by zero returns all ones.
  assign o_quotient  = w_zero ? '1 : o_dividend;
  assign o_remainder = w_zero ? o_dividend : '0;

endmodule

// File: rtl/ysyx_22040632_div_seq.sv
// rtl/ysyx_22040632_div_seq.sv - EXU-to-divider sequencer with fast path and one-entry result cache
module ysyx_22040632_div_seq
  import ysyx_22040632_div_seq_pkg::*;
#(
  parameter int XLEN     = 64,
  parameter int CACHE_EN = 1,
  parameter int CNT_W    = 32
) (
  input  logic            clk,
  input  logic            rrst_n,
  input  logic            i_req_valid,
  input  logic            i_req_signed,
  input  logic            i_req_word,
  input  logic            i_req_rem,
  input  logic [XLEN-1:0] i_req_dividend,
  input  logic [XLEN-1:0] i_req_divisor,
  input  logic            i_flush,
  output logic            o_resp_valid,
  output logic [XLEN-1:0] o_resp_data,
  output logic            o_busy,
  output logic            o_div_valid,
  input  logic            i_div_ready,
  output logic            o_div_signed,
  output logic            o_div_word,
  output logic [XLEN-1:0] o_div_dividend,
  output logic [XLEN-1:0] o_div_divisor,
  output logic            o_div_flush,
  input  logic            i_div_out_valid,
  input  logic [XLEN-1:0] i_div_quotient,
  input  logic [XLEN-1:0] i_div_remainder,
  output logic [CNT_W-1:0] o_cnt_div,
  output logic [CNT_W-1:0] o_cnt_fast
);

  div_state_e       r_state;
  div_key_t         r_key;
  logic             r_rem;
  logic [XLEN-1:0]  r_resp_data;
  logic             r_cache_vld;
  div_key_t         r_cache_key;
  logic [XLEN-1:0]  r_cache_quo;
  logic [XLEN-1:0]  r_cache_rem;
  logic [CNT_W-1:0] r_cnt_div;
  logic [CNT_W-1:0] r_cnt_fast;

  logic [XLEN-1:0]  w_ext_dvd;
  logic [XLEN-1:0]  w_ext_dvs;
  logic             w_special;
  logic [XLEN-1:0]  w_sp_quo;
  logic [XLEN-1:0]  w_sp_rem;
  div_key_t         w_key;
  logic             w_accept;
  logic             w_hit;
  logic [XLEN-1:0]  w_fast_res;
  logic [XLEN-1:0]  w_div_res;
  logic             w_resp_valid;

  ysyx_22040632_div_special u_special (
    .i_signed    (i_req_signed),
    .i_word      (i_req_word),
    .i_dividend  (i_req_dividend),
    .i_divisor   (i_req_divisor),
    .o_dividend  (w_ext_dvd),
    .o_divisor   (w_ext_dvs),
    .o_special   (w_special),
    .o_quotient  (w_sp_quo),
    .o_remainder (w_sp_rem)
  );

  assign w_key      = {i_req_signed, i_req_word, w_ext_dvd, w_ext_dvs};
  assign w_accept   = (r_state == S_IDLE) && i_req_valid && !i_flush;
  // The remainder/quotient select is not part of the key, so a div/rem pair shares one entry.
  assign w_hit      = (CACHE_EN != 0) && r_cache_vld && (r_cache_key == w_key);
  assign w_fast_res = w_special ? (i_req_rem ? w_sp_rem : w_sp_quo)
                                : (i_req_rem ? r_cache_rem : r_cache_quo);
  assign w_div_res  = r_rem ? i_div_remainder : i_div_quotient;

  always_ff @(posedge clk or negedge rrst_n) begin
    if (!rrst_n) begin
      r_state     <= S_IDLE;
      r_key       <= '0;
      r_rem       <= 1'b0;
      r_resp_data <= '0;
      r_cache_vld <= 1'b0;
      r_cache_key <= '0;
      r_cache_quo <= '0;
      r_cache_rem <= '0;
      r_cnt_div   <= '0;
      r_cnt_fast  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_key <= w_key;
            r_rem <= i_req_rem;
            if (w_special || w_hit) begin
              r_resp_data <= i_req_word ? sext_w(w_fast_res) : w_fast_res;
              r_cnt_fast  <= r_cnt_fast + CNT_W'(1);
              r_state     <= S_RESP;
            end else begin
              r_state <= S_ISSUE;
            end
          end
        end
        S_ISSUE: begin
          if (i_flush)          r_state <= S_IDLE;
          else if (i_div_ready) r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (i_flush) begin
            r_state <= S_IDLE;
          end else if (i_div_out_valid) begin
            r_cache_vld <= 1'b1;
            r_cache_key <= r_key;
            r_cache_quo <= i_div_quotient;
            r_cache_rem <= i_div_remainder;
            r_cnt_div   <= r_cnt_div + CNT_W'(1);
            r_resp_data <= r_key.word ? sext_w(w_div_res) : w_div_res;
            r_state     <= S_RESP;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign w_resp_valid   = (r_state == S_RESP) && !i_flush;
  assign o_resp_valid   = w_resp_valid;
  assign o_resp_data    = r_resp_data;
  assign o_busy         = i_req_valid && !w_resp_valid;
  assign o_div_valid    = (r_state == S_ISSUE);
  assign o_div_signed   = r_key.sgn;
  assign o_div_word     = r_key.word;
  assign o_div_dividend = r_key.dividend;
  assign o_div_divisor  = r_key.divisor;
  assign o_div_flush    = i_flush && ((r_state == S_ISSUE) || (r_state == S_WAIT));
  assign o_cnt_div      = r_cnt_div;
  assign o_cnt_fast     = r_cnt_fast;

endmodule

// File: tb/tb_ysyx_22040632_div_seq.sv
// tb/tb_ysyx_22040632_div_seq.sv - directed self-checking bench for the divide sequencer
module tb_ysyx_22040632_div_seq;

  logic        clk = 1'b0;
  logic        rrst_n;
  logic        req_valid, req_signed, req_word, req_rem;
  logic [63:0] req_dividend, req_divisor;
  logic        flush;
  logic        resp_valid;
  logic [63:0] resp_data;
  logic        busy;
  logic        div_valid, div_ready, div_signed, div_word, div_flush, div_out_valid;
  logic [63:0] div_dividend, div_divisor, div_quotient, div_remainder;
  logic [31:0] cnt_div, cnt_fast;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ysyx_22040632_div_seq dut (
    .clk             (clk),
    .rrst_n          (rrst_n),
    .i_req_valid     (req_valid),
    .i_req_signed    (req_signed),
    .i_req_word      (req_word),
    .i_req_rem       (req_rem),
    .i_req_dividend  (req_dividend),
    .i_req_divisor   (req_divisor),
    .i_flush         (flush),
    .o_resp_valid    (resp_valid),
    .o_resp_data     (resp_data),
    .o_busy          (busy),
    .o_div_valid     (div_valid),
    .i_div_ready     (div_ready),
    .o_div_signed    (div_signed),
    .o_div_word      (div_word),
    .o_div_dividend  (div_dividend),
    .o_div_divisor   (div_divisor),
    .o_div_flush     (div_flush),
    .i_div_out_valid (div_out_valid),
    .i_div_quotient  (div_quotient),
    .i_div_remainder (div_remainder),
    .o_cnt_div       (cnt_div),
    .o_cnt_fast      (cnt_fast)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input logic s, input logic w, input logic r,
                         input logic [63:0] a, input logic [63:0] b);
    req_valid = 1'b1; req_signed = s; req_word = w; req_rem = r;
    req_dividend = a; req_divisor = b;
  endtask

  initial begin
    rrst_n = 1'b0; req_valid = 0; req_signed = 0; req_word = 0; req_rem = 0;
    req_dividend = 0; req_divisor = 0; flush = 0; div_ready = 0;
    div_out_valid = 0; div_quotient = 0; div_remainder = 0;
    tick; tick;
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_resp_data", resp_data, 0);
    chk("rst_div_valid", div_valid, 0);
    chk("rst_cnt_div", cnt_div, 0);
    chk("rst_cnt_fast", cnt_fast, 0);
    rrst_n = 1'b1;
    tick;

    // divu 100/7 through the divider
    set_req(0, 0, 0, 64'd100, 64'd7);
    #1;
    chk("t1_busy_idle", busy, 1);
    chk("t1_no_div_valid_idle", div_valid, 0);
    tick;
    chk("t1_div_valid", div_valid, 1);
    chk("t1_div_dividend", div_dividend, 64'd100);
    chk("t1_div_divisor", div_divisor, 64'd7);
    tick;
    chk("t1_div_valid_held", div_valid, 1);
    div_ready = 1;
    tick;
    div_ready = 0;
    #1;
    chk("t1_div_valid_drop", div_valid, 0);
    tick; tick;
    div_out_valid = 1; div_quotient = 64'd14; div_remainder = 64'd2;
    tick;
    div_out_valid = 0;
    #1;
    chk("t1_resp_valid", resp_valid, 1);
    chk("t1_resp_data", resp_data, 64'd14);
    chk("t1_busy_resp", busy, 0);
    chk("t1_cnt_div", cnt_div, 1);
    tick;
    chk("t1_pulse_end", resp_valid, 0);
    chk("t1_no_reaccept", div_valid, 0);

    // remu 100/7 hits the cache
    req_rem = 1;
    tick;
    chk("t2_resp_valid", resp_valid, 1);
    chk("t2_resp_data", resp_data, 64'd2);
    chk("t2_no_div_valid", div_valid, 0);
    chk("t2_cnt_fast", cnt_fast, 1);
    req_valid = 0;
    tick;
    chk("t2_pulse_end", resp_valid, 0);

    // div / rem by zero
    set_req(1, 0, 0, 64'h123, 64'd0);
    tick;
    chk("t3_div_resp_valid", resp_valid, 1);
    chk("t3_div_data", resp_data, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("t3_no_div_valid", div_valid, 0);
    req_rem = 1;
    tick;
    chk("t3_gap", resp_valid, 0);
    tick;
    chk("t3_rem_data", resp_data, 64'h123);
    chk("t3_cnt_fast", cnt_fast, 3);
    req_valid = 0;
    tick;

    // divw/remw signed overflow
    set_req(1, 1, 0, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF);
    tick;
    chk("t4_divw_valid", resp_valid, 1);
    chk("t4_divw_data", resp_data, 64'hFFFF_FFFF_8000_0000);
    req_rem = 1;
    tick;
    tick;
    chk("t4_remw_valid", resp_valid, 1);
    chk("t4_remw_data", resp_data, 64'd0);
    chk("t4_cnt_fast", cnt_fast, 5);
    chk("t4_cnt_div", cnt_div, 1);
    req_valid = 0;
    tick;

    // flush in WAIT with a coincident divider result
    set_req(0, 0, 0, 64'd1000, 64'd10);
    tick;
    div_ready = 1;
    tick;
    div_ready = 0;
    tick;
    flush = 1; div_out_valid = 1; div_quotient = 64'd100; div_remainder = 64'd0;
    #1;
    chk("t5_div_flush", div_flush, 1);
    tick;
    flush = 0; div_out_valid = 0; req_valid = 0;
    #1;
    chk("t5_no_resp", resp_valid, 0);
    chk("t5_flush_end", div_flush, 0);
    chk("t5_cnt_div", cnt_div, 1);
    chk("t5_idle", div_valid, 0);
    tick;
    chk("t5_still_no_resp", resp_valid, 0);
    req_valid = 1;
    tick;
    chk("t5_repeat_miss", div_valid, 1);
    chk("t5_cnt_fast", cnt_fast, 5);

    // reset while waiting on the divider
    div_ready = 1;
    tick;
    div_ready = 0; req_valid = 0;
    #2;
    rrst_n = 0;
    #1;
    chk("t6_rst_div_valid", div_valid, 0);
    chk("t6_rst_div_dividend", div_dividend, 0);
    chk("t6_rst_resp_data", resp_data, 0);
    chk("t6_rst_resp_valid", resp_valid, 0);
    chk("t6_rst_cnt_div", cnt_div, 0);
    chk("t6_rst_cnt_fast", cnt_fast, 0);
    tick;
    rrst_n = 1;
    tick;
    set_req(0, 0, 0, 64'd100, 64'd7);
    tick;
    chk("t6_full_path", div_valid, 1);
    div_ready = 1;
    tick;
    div_ready = 0;
    tick;
    div_out_valid = 1; div_quotient = 64'd14; div_remainder = 64'd2;
    tick;
    div_out_valid = 0;
    #1;
    chk("t6_resp_valid", resp_valid, 1);
    chk("t6_resp_data", resp_data, 64'd14);
    chk("t6_cnt_div", cnt_div, 1);
    req_valid = 0;
    tick;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
